// File: rtl/zoom_copier.sv
// Copies the source image ROM into the framebuffer with nearest-neighbour zoom (1x/2x/4x),
// walking destination pixels in raster order and writing one pixel per clock.
//
// state | meaning
// IDLE  | waiting for first start, outputs quiet
// RUN   | issuing one ROM read per destination pixel
// DRAIN | waiting ROM_LAT clocks for the last reads to land
// DONE  | frame complete, done held until next start
module zoom_copier #(
    parameter int SRC_W   = 160,
    parameter int SRC_H   = 120,
    parameter int DST_W   = 640,
    parameter int DST_H   = 480,
    parameter int ADDR_W  = 19,
    parameter int ROM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [ADDR_W-1:0] ram_wraddr,
    output logic [7:0]        ram_data,
    output logic              ram_wren,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] SRC_W_A = ADDR_W'(SRC_W);
    localparam logic [ADDR_W-1:0] SRC_H_A = ADDR_W'(SRC_H);
    localparam logic [ADDR_W-1:0] DST_W_A = ADDR_W'(DST_W);
    localparam logic [ADDR_W-1:0] LAST_X  = ADDR_W'(DST_W - 1);
    localparam logic [ADDR_W-1:0] LAST_Y  = ADDR_W'(DST_H - 1);
    localparam int                CNT_W   = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
    localparam logic [CNT_W-1:0]  DRAIN_LOAD = CNT_W'(ROM_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   x_q, x_d;
    logic [ADDR_W-1:0]   y_q, y_d;
    logic [1:0]          s_q, s_d;
    logic [CNT_W-1:0]    drain_q, drain_d;

    logic [ADDR_W-1:0]   pipe_addr_q [ROM_LAT];
    logic [ADDR_W-1:0]   pipe_addr_d [ROM_LAT];
    logic [ROM_LAT-1:0]  pipe_inwin_q, pipe_inwin_d;
    logic [ROM_LAT-1:0]  pipe_valid_q, pipe_valid_d;
    logic [ADDR_W-1:0]   last_addr_q, last_addr_d;
    logic [7:0]          last_data_q, last_data_d;

    logic [ADDR_W-1:0]   sx, sy, src_addr, dst_addr;
    logic                inwin, last_pixel, push;

    assign sx         = x_q >> s_q;
    assign sy         = y_q >> s_q;
    assign inwin      = (sx < SRC_W_A) && (sy < SRC_H_A);
    assign src_addr   = sy * SRC_W_A + sx;
    assign dst_addr   = y_q * DST_W_A + x_q;
    assign last_pixel = (x_q == LAST_X) && (y_q == LAST_Y);

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        s_d      = s_q;
        drain_d  = drain_q;
        busy     = 1'b0;
        done     = 1'b0;
        rom_addr = '0;
        push     = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                done = (state_q == S_DONE);
                if (start) begin
                    state_d = S_RUN;
                    x_d     = '0;
                    y_d     = '0;
                    // mode 11 is reserved and treated as 1x
                    case (mode)
                        2'b01:   s_d = 2'd1;
                        2'b10:   s_d = 2'd2;
                        default: s_d = 2'd0;
                    endcase
                end
            end
            S_RUN: begin
                busy     = 1'b1;
                push     = 1'b1;
                rom_addr = inwin ? src_addr : '0;
                if (last_pixel) begin
                    state_d = S_DRAIN;
                    drain_d = DRAIN_LOAD;
                end else if (x_q == LAST_X) begin
                    x_d = '0;
                    y_d = y_q + 1'b1;
                end else begin
                    x_d = x_q + 1'b1;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (drain_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Delay line tracks the ROM latency so each write pairs with its own rom_data.
    always_comb begin
        pipe_addr_d     = pipe_addr_q;
        pipe_inwin_d    = pipe_inwin_q;
        pipe_valid_d    = pipe_valid_q;
        pipe_addr_d[0]  = dst_addr;
        pipe_inwin_d[0] = inwin;
        pipe_valid_d[0] = push;
        for (int i = 1; i < ROM_LAT; i++) begin
            pipe_addr_d[i]  = pipe_addr_q[i-1];
            pipe_inwin_d[i] = pipe_inwin_q[i-1];
            pipe_valid_d[i] = pipe_valid_q[i-1];
        end
    end

    always_comb begin
        ram_wren    = pipe_valid_q[ROM_LAT-1];
        ram_wraddr  = last_addr_q;
        ram_data    = last_data_q;
        if (ram_wren) begin
            ram_wraddr = pipe_addr_q[ROM_LAT-1];
            ram_data   = pipe_inwin_q[ROM_LAT-1] ? rom_data : 8'h00;
        end
        last_addr_d = ram_wraddr;
        last_data_d = ram_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            s_q          <= '0;
            drain_q      <= '0;
            pipe_inwin_q <= '0;
            pipe_valid_q <= '0;
            last_addr_q  <= '0;
            last_data_q  <= '0;
            for (int i = 0; i < ROM_LAT; i++) begin
                pipe_addr_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            s_q          <= s_d;
            drain_q      <= drain_d;
            pipe_inwin_q <= pipe_inwin_d;
            pipe_valid_q <= pipe_valid_d;
            last_addr_q  <= last_addr_d;
            last_data_q  <= last_data_d;
            pipe_addr_q  <= pipe_addr_d;
        end
    end

endmodule

// File: tb/tb_zoom_copier.sv
// Directed bench for zoom_copier on a scaled-down geometry (8x6 source, 32x24 frame),
// with one instance at ROM latency 2 and one at ROM latency 1 running side by side.
module tb_zoom_copier;

    localparam int SW     = 8;
    localparam int SH     = 6;
    localparam int DW     = 32;
    localparam int DH     = 24;
    localparam int AW     = 19;
    localparam int NPIX   = DW * DH;
    localparam int BUDGET = 3000;

    logic          clk;
    logic          reset;
    logic          start;
    logic [1:0]    mode;

    logic [AW-1:0] rom_addr_a, ram_wraddr_a, rom_a_r;
    logic [7:0]    rom_data_a, ram_data_a;
    logic          ram_wren_a, busy_a, done_a;
    logic [AW-1:0] rom_addr_b, ram_wraddr_b;
    logic [7:0]    rom_data_b, ram_data_b;
    logic          ram_wren_b, busy_b, done_b;

    logic [7:0]    ram_a [NPIX];
    logic [7:0]    ram_b [NPIX];
    logic [7:0]    snap  [NPIX];

    int wr_total_a = 0, wr_total_b = 0;
    int wr_base_a  = 0, wr_base_b  = 0;
    int seq_bad_a  = 0, seq_bad_b  = 0;
    int both_hi    = 0;
    int errors     = 0;
    int checks     = 0;

    zoom_copier #(.SRC_W(SW), .SRC_H(SH), .DST_W(DW), .DST_H(DH), .ADDR_W(AW), .ROM_LAT(2)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .rom_addr(rom_addr_a), .rom_data(rom_data_a),
        .ram_wraddr(ram_wraddr_a), .ram_data(ram_data_a), .ram_wren(ram_wren_a),
        .busy(busy_a), .done(done_a)
    );

    zoom_copier #(.SRC_W(SW), .SRC_H(SH), .DST_W(DW), .DST_H(DH), .ADDR_W(AW), .ROM_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .rom_addr(rom_addr_b), .rom_data(rom_data_b),
        .ram_wraddr(ram_wraddr_b), .ram_data(ram_data_b), .ram_wren(ram_wren_b),
        .busy(busy_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM content is the low byte of its address
    always @(posedge clk) begin
        rom_a_r    <= rom_addr_a;
        rom_data_a <= rom_a_r[7:0];
        rom_data_b <= rom_addr_b[7:0];
    end

    always @(posedge clk) begin
        if (ram_wren_a) begin
            if (int'(ram_wraddr_a) != wr_total_a - wr_base_a) seq_bad_a <= seq_bad_a + 1;
            if (int'(ram_wraddr_a) < NPIX) ram_a[int'(ram_wraddr_a)] <= ram_data_a;
            wr_total_a <= wr_total_a + 1;
        end
        if (ram_wren_b) begin
            if (int'(ram_wraddr_b) != wr_total_b - wr_base_b) seq_bad_b <= seq_bad_b + 1;
            if (int'(ram_wraddr_b) < NPIX) ram_b[int'(ram_wraddr_b)] <= ram_data_b;
            wr_total_b <= wr_total_b + 1;
        end
        if ((busy_a && done_a) || (busy_b && done_b)) both_hi <= both_hi + 1;
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pix(input int x, input int y, input int s);
        int sx, sy;
        sx = x >> s;
        sy = y >> s;
        if (sx < SW && sy < SH) return 8'((sy * SW + sx) & 255);
        return 8'h00;
    endfunction

    task automatic check_frame(input int s, input string tag);
        int ma, mb;
        ma = 0;
        mb = 0;
        for (int y = 0; y < DH; y++) begin
            for (int x = 0; x < DW; x++) begin
                if (ram_a[y*DW+x] !== pix(x, y, s)) ma++;
                if (ram_b[y*DW+x] !== pix(x, y, s)) mb++;
            end
        end
        chk({tag, "_frame_lat2_bad_pixels"}, ma, 0);
        chk({tag, "_frame_lat1_bad_pixels"}, mb, 0);
    endtask

    task automatic pulse_start(input logic [1:0] m);
        wr_base_a = wr_total_a;
        wr_base_b = wr_total_b;
        mode  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_frame(input logic [1:0] m, input int disturb_at, input string tag);
        int n, dn_a, dn_b, fw_a, fw_b;
        dn_a = -1; dn_b = -1; fw_a = -1; fw_b = -1;
        @(negedge clk);
        pulse_start(m);
        n = 1;
        while (n <= BUDGET && (dn_a < 0 || dn_b < 0)) begin
            if (fw_a < 0 && ram_wren_a) fw_a = n;
            if (fw_b < 0 && ram_wren_b) fw_b = n;
            if (dn_a < 0 && done_a) dn_a = n;
            if (dn_b < 0 && done_b) dn_b = n;
            if (n == disturb_at) begin
                start = 1'b1;
                mode  = ~m;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk({tag, "_first_write_lat2"}, fw_a, 3);
        chk({tag, "_first_write_lat1"}, fw_b, 2);
        chk({tag, "_done_cycle_lat2"}, dn_a, 1 + NPIX + 2);
        chk({tag, "_done_cycle_lat1"}, dn_b, 1 + NPIX + 1);
        chk({tag, "_writes_lat2"}, wr_total_a - wr_base_a, NPIX);
        chk({tag, "_writes_lat1"}, wr_total_b - wr_base_b, NPIX);
        chk({tag, "_seq_addr_errs"}, seq_bad_a + seq_bad_b, 0);
        chk({tag, "_idle_outputs"}, {rom_addr_a, ram_wren_a, busy_a, done_a}, {19'd0, 3'b001});
    endtask

    initial begin
        int n;
        int ms;
        reset = 1'b0;
        start = 1'b0;
        mode  = 2'b00;
        repeat (3) @(negedge clk);
        chk("rst_rom_addr",   rom_addr_a,   0);
        chk("rst_ram_wraddr", ram_wraddr_a, 0);
        chk("rst_ram_data",   ram_data_a,   0);
        chk("rst_ram_wren",   ram_wren_a,   0);
        chk("rst_busy_done",  {busy_a, done_a, busy_b, done_b}, 0);
        reset = 1'b1;
        @(negedge clk);

        // T1: 4x fills the whole frame
        run_frame(2'b10, 0, "t1");
        chk("t1_src_1_0",   ram_a[DW*1+5], 8'h01);
        chk("t1_last_pix",  ram_a[DW*23+31], 8'h2F);
        check_frame(2, "t1");

        // T2: 2x, window 16x12
        run_frame(2'b01, 0, "t2");
        chk("t2_win_corner", ram_a[DW*11+15], 8'h2F);
        chk("t2_src_1_1",    ram_a[DW*2+3], 8'h09);
        chk("t2_right_black", ram_a[16], 8'h00);
        chk("t2_below_black", ram_a[DW*12], 8'h00);
        check_frame(1, "t2");

        // T3: 1x and reserved mode give the same image
        run_frame(2'b00, 0, "t3a");
        chk("t3_last_in_row", ram_a[7], 8'h07);
        chk("t3_right_black", ram_a[8], 8'h00);
        chk("t3_win_corner",  ram_a[DW*5+7], 8'h2F);
        chk("t3_below_black", ram_a[DW*6], 8'h00);
        check_frame(0, "t3a");
        for (int i = 0; i < NPIX; i++) snap[i] = ram_a[i];
        run_frame(2'b11, 0, "t3b");
        ms = 0;
        for (int i = 0; i < NPIX; i++) if (ram_a[i] !== snap[i]) ms++;
        chk("t3_mode11_vs_mode00", ms, 0);
        check_frame(0, "t3b");

        // T4: start and mode toggled mid-run have no effect
        run_frame(2'b10, 100, "t4");
        check_frame(2, "t4");

        // T5: async reset mid-stream, then a clean frame
        @(negedge clk);
        pulse_start(2'b10);
        n = 0;
        while (n < BUDGET && (wr_total_a - wr_base_a) < 300) begin
            @(negedge clk);
            n++;
        end
        chk("t5_reached_write_300", wr_total_a - wr_base_a, 300);
        chk("t5_wren_before_reset", ram_wren_a, 1);
        reset = 1'b0;
        #1;
        chk("t5_wren_drops",  {ram_wren_a, ram_wren_b}, 0);
        chk("t5_busy_done",   {busy_a, done_a, busy_b, done_b}, 0);
        chk("t5_rom_addr",    rom_addr_a, 0);
        @(negedge clk);
        reset = 1'b1;
        run_frame(2'b10, 0, "t5");
        check_frame(2, "t5");

        chk("busy_and_done_overlap", both_hi, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
